// File: rtl/croc_pkg.sv
// Shared croc FPGA boot-path types: sequencer state encoding and the
// per-state output decode used by soc_boot_seq.
package croc_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    HOLD_RST  = 3'd1,
    DELAY     = 3'd2,
    IDLE      = 3'd3,
    RUN       = 3'd4,
    DONE      = 3'd5
  } boot_state_e;

  function automatic int unsigned max_uint(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // The SoC only leaves reset once the clock is locked and every reset cause has been held off.
  function automatic logic state_releases_rst(input boot_state_e s);
    return !(s == WAIT_LOCK || s == HOLD_RST);
  endfunction

  function automatic logic state_fetches(input boot_state_e s);
    return (s == RUN) || (s == DONE);
  endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer followed by a stability counter for a raw, bouncing,
// asynchronous board input (push-button or slide switch).
module debounce #(
  parameter int unsigned Cycles = 20000
) (
  input  logic soc_clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic deb_o
);

  localparam int unsigned     CntW    = $clog2(Cycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(Cycles - 1);

  logic            sync1_q, sync2_q;
  logic            deb_q, deb_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  // A single cycle where the input agrees with the accepted value restarts the stability count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CntLast) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/soc_boot_seq.sv
// Boot sequencer for the croc SoC on FPGA: waits for clock lock, holds the SoC
// in reset, delays fetch enable, then tracks the program run to completion.
module soc_boot_seq
  import croc_pkg::*;
#(
  parameter int unsigned DebounceCycles   = 20000,
  parameter int unsigned ResetHoldCycles  = 64,
  parameter int unsigned FetchDelayCycles = 16
) (
  input  logic       soc_clk,
  input  logic       rst_n,
  input  logic       clk_locked_i,
  input  logic       btn_rst_i,
  input  logic       fetch_sw_i,
  input  logic       vio_rst_i,
  input  logic       vio_fetch_i,
  input  logic       status_i,
  output logic       soc_rst_no,
  output logic       soc_fetch_en_o,
  output logic [2:0] state_o,
  output logic       done_o
);

  localparam int unsigned     CntW      = $clog2(max_uint(ResetHoldCycles, FetchDelayCycles)) + 1;
  localparam logic [CntW-1:0] HoldLast  = CntW'(ResetHoldCycles - 1);
  localparam logic [CntW-1:0] DelayLast = CntW'(FetchDelayCycles);

  logic            lock_meta_q, lock_sync_q;
  logic            btn_deb, sw_deb;
  logic            rst_req, fetch_req;
  boot_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            soc_rst_n_q, soc_rst_n_d;
  logic            fetch_en_q, fetch_en_d;

  debounce #(
    .Cycles (DebounceCycles)
  ) u_btn_debounce (
    .soc_clk (soc_clk),
    .rst_n   (rst_n),
    .raw_i   (btn_rst_i),
    .deb_o   (btn_deb)
  );

  debounce #(
    .Cycles (DebounceCycles)
  ) u_sw_debounce (
    .soc_clk (soc_clk),
    .rst_n   (rst_n),
    .raw_i   (fetch_sw_i),
    .deb_o   (sw_deb)
  );

  // Lock is a level from the clock wizard; it is not debounced, only synchronized.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= clk_locked_i;
      lock_sync_q <= lock_meta_q;
    end
  end

  assign rst_req   = btn_deb | vio_rst_i | ~lock_sync_q;
  assign fetch_req = sw_deb | vio_fetch_i;

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      soc_rst_n_q <= 1'b0;
      fetch_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      soc_rst_n_q <= soc_rst_n_d;
      fetch_en_q  <= fetch_en_d;
    end
  end

  // Lock loss beats everything, then any reset cause; the shared counter restarts on every state change.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    soc_rst_n_d = state_releases_rst(state_q);
    fetch_en_d  = state_fetches(state_q);

    if (state_q != WAIT_LOCK && !lock_sync_q) begin
      state_d = WAIT_LOCK;
    end else if (state_q != WAIT_LOCK && state_q != HOLD_RST && rst_req) begin
      state_d = HOLD_RST;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          if (lock_sync_q) state_d = HOLD_RST;
        end
        HOLD_RST: begin
          if (rst_req) begin
            cnt_d = '0;
          end else if (cnt_q == HoldLast) begin
            state_d = DELAY;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        DELAY: begin
          if (cnt_q == DelayLast) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        IDLE: begin
          if (fetch_req) state_d = RUN;
        end
        RUN: begin
          if (status_i) state_d = DONE;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = WAIT_LOCK;
        end
      endcase
    end

    if (state_d != state_q) cnt_d = '0;
  end

  assign soc_rst_no     = soc_rst_n_q;
  assign soc_fetch_en_o = fetch_en_q;
  assign state_o        = state_q;
  assign done_o         = (state_q == DONE);

endmodule

// File: tb/tb_soc_boot_seq.sv
// Directed bench for soc_boot_seq with short debounce/hold/delay settings;
// expected output vectors are {state, soc_rst_no, fetch_en, done}.
module tb_soc_boot_seq;

  localparam int unsigned DebCyc   = 8;
  localparam int unsigned HoldCyc  = 4;
  localparam int unsigned DelayCyc = 3;

  localparam logic [2:0] S_WAIT  = 3'd0;
  localparam logic [2:0] S_HOLD  = 3'd1;
  localparam logic [2:0] S_DELAY = 3'd2;
  localparam logic [2:0] S_IDLE  = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic       soc_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_locked_i = 1'b0;
  logic       btn_rst_i = 1'b0;
  logic       fetch_sw_i = 1'b0;
  logic       vio_rst_i = 1'b0;
  logic       vio_fetch_i = 1'b0;
  logic       status_i = 1'b0;
  logic       soc_rst_no;
  logic       soc_fetch_en_o;
  logic [2:0] state_o;
  logic       done_o;

  int nVectors = 0;
  int nMiscompares = 0;

  always #5 soc_clk = ~soc_clk;

  soc_boot_seq #(
    .DebounceCycles   (DebCyc),
    .ResetHoldCycles  (HoldCyc),
    .FetchDelayCycles (DelayCyc)
  ) dut (
    .soc_clk        (soc_clk),
    .rst_n          (rst_n),
    .clk_locked_i   (clk_locked_i),
    .btn_rst_i      (btn_rst_i),
    .fetch_sw_i     (fetch_sw_i),
    .vio_rst_i      (vio_rst_i),
    .vio_fetch_i    (vio_fetch_i),
    .status_i       (status_i),
    .soc_rst_no     (soc_rst_no),
    .soc_fetch_en_o (soc_fetch_en_o),
    .state_o        (state_o),
    .done_o         (done_o)
  );

  function automatic logic [5:0] expVec(input logic [2:0] st, input logic rstn, input logic fen);
    return {st, rstn, fen, (st == S_DONE)};
  endfunction

  function automatic logic [5:0] obsVec();
    return {state_o, soc_rst_no, soc_fetch_en_o, done_o};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge soc_clk);
    #1;
  endtask

  task automatic waitState(input logic [2:0] target, input int budget, output bit reached);
    reached = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (state_o === target) begin
        reached = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    rst_n = 1'b0;
    tick(2);
    exp = expVec(S_WAIT, 1'b0, 1'b0);
    nVectors++;
    if (obsVec() !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL reset_state: got %b, expected %b", obsVec(), exp);
    end
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      nVectors++;
      if (obsVec() !== exp) begin
        nMiscompares++;
        $display("[TB] FAIL wait_no_lock k=%0d: got %b, expected %b", k, obsVec(), exp);
      end
    end
  endtask

  task automatic test_power_up();
    logic [5:0] exp;
    logic [2:0] st;
    clk_locked_i = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      if (k < 3)       st = S_WAIT;
      else if (k < 7)  st = S_HOLD;
      else if (k < 11) st = S_DELAY;
      else             st = S_IDLE;
      exp = expVec(st, (k >= 8), 1'b0);
      nVectors++;
      if (obsVec() !== exp) begin
        nMiscompares++;
        $display("[TB] FAIL power_up k=%0d: got %b, expected %b", k, obsVec(), exp);
      end
    end
  endtask

  task automatic test_btn_reset();
    logic [5:0] exp;
    bit reached;
    btn_rst_i = 1'b1;
    exp = expVec(S_IDLE, 1'b1, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (k == 5) btn_rst_i = 1'b0;
      nVectors++;
      if (obsVec() !== exp) begin
        nMiscompares++;
        $display("[TB] FAIL btn_short k=%0d: got %b, expected %b", k, obsVec(), exp);
      end
    end
    btn_rst_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      exp = expVec((k >= 11) ? S_HOLD : S_IDLE, (k < 12), 1'b0);
      nVectors++;
      if (obsVec() !== exp) begin
        nMiscompares++;
        $display("[TB] FAIL btn_long k=%0d: got %b, expected %b", k, obsVec(), exp);
      end
    end
    btn_rst_i = 1'b0;
    waitState(S_IDLE, 60, reached);
    nVectors++;
    if (!reached) begin
      nMiscompares++;
      $display("[TB] FAIL btn_recover: got state %0d, expected %0d", state_o, S_IDLE);
    end
  endtask

  task automatic test_fetch();
    logic [5:0] exp;
    vio_fetch_i = 1'b1;
    tick(1);
    exp = expVec(S_RUN, 1'b1, 1'b0);
    nVectors++;
    if (obsVec() !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL fetch_run: got %b, expected %b", obsVec(), exp);
    end
    tick(1);
    exp = expVec(S_RUN, 1'b1, 1'b1);
    nVectors++;
    if (obsVec() !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL fetch_en: got %b, expected %b", obsVec(), exp);
    end
    status_i = 1'b1;
    tick(1);
    status_i = 1'b0;
    vio_fetch_i = 1'b0;
    exp = expVec(S_DONE, 1'b1, 1'b1);
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) tick(1);
      nVectors++;
      if (obsVec() !== exp) begin
        nMiscompares++;
        $display("[TB] FAIL done_hold k=%0d: got %b, expected %b", k, obsVec(), exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    bit reached;
    vio_rst_i = 1'b1;
    tick(1);
    vio_rst_i = 1'b0;
    exp = expVec(S_HOLD, 1'b1, 1'b1);
    nVectors++;
    if (obsVec() !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL done_to_hold: got %b, expected %b", obsVec(), exp);
    end
    tick(1);
    exp = expVec(S_HOLD, 1'b0, 1'b0);
    nVectors++;
    if (obsVec() !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL hold_outputs: got %b, expected %b", obsVec(), exp);
    end
    waitState(S_IDLE, 20, reached);
    nVectors++;
    if (!reached) begin
      nMiscompares++;
      $display("[TB] FAIL rerun_idle: got state %0d, expected %0d", state_o, S_IDLE);
    end
    vio_fetch_i = 1'b1;
    tick(1);
    vio_fetch_i = 1'b0;
    tick(1);
    exp = expVec(S_RUN, 1'b1, 1'b1);
    nVectors++;
    if (obsVec() !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL run_fetch_drop: got %b, expected %b", obsVec(), exp);
    end
  endtask

  task automatic test_lock_loss();
    logic [5:0] exp;
    clk_locked_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      if (k < 3)       exp = expVec(S_RUN, 1'b1, 1'b1);
      else if (k == 3) exp = expVec(S_WAIT, 1'b1, 1'b1);
      else             exp = expVec(S_WAIT, 1'b0, 1'b0);
      nVectors++;
      if (obsVec() !== exp) begin
        nMiscompares++;
        $display("[TB] FAIL lock_loss k=%0d: got %b, expected %b", k, obsVec(), exp);
      end
    end
  endtask

  task automatic test_vio_hold();
    logic [5:0] exp;
    clk_locked_i = 1'b1;
    tick(3);
    exp = expVec(S_HOLD, 1'b0, 1'b0);
    nVectors++;
    if (obsVec() !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL relock_hold: got %b, expected %b", obsVec(), exp);
    end
    tick(2);
    vio_rst_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      nVectors++;
      if (obsVec() !== exp) begin
        nMiscompares++;
        $display("[TB] FAIL vio_hold k=%0d: got %b, expected %b", k, obsVec(), exp);
      end
    end
    vio_rst_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      if (k < 4)       exp = expVec(S_HOLD, 1'b0, 1'b0);
      else if (k == 4) exp = expVec(S_DELAY, 1'b0, 1'b0);
      else             exp = expVec(S_DELAY, 1'b1, 1'b0);
      nVectors++;
      if (obsVec() !== exp) begin
        nMiscompares++;
        $display("[TB] FAIL vio_release k=%0d: got %b, expected %b", k, obsVec(), exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] exp;
    bit reached;
    waitState(S_IDLE, 20, reached);
    nVectors++;
    if (!reached) begin
      nMiscompares++;
      $display("[TB] FAIL arst_idle: got state %0d, expected %0d", state_o, S_IDLE);
    end
    vio_fetch_i = 1'b1;
    tick(2);
    exp = expVec(S_RUN, 1'b1, 1'b1);
    nVectors++;
    if (obsVec() !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL arst_run: got %b, expected %b", obsVec(), exp);
    end
    #2 rst_n = 1'b0;
    #1;
    exp = expVec(S_WAIT, 1'b0, 1'b0);
    nVectors++;
    if (obsVec() !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL arst_immediate: got %b, expected %b", obsVec(), exp);
    end
    vio_fetch_i = 1'b0;
    tick(2);
    nVectors++;
    if (obsVec() !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL arst_held: got %b, expected %b", obsVec(), exp);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_btn_reset();
    test_fetch();
    test_back_to_back();
    test_lock_loss();
    test_vio_hold();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
